// File: rtl/cpu_params_pkg.sv
// Machine-wide sizing shared by the issue-stage blocks: register file and
// reorder-buffer index widths, plus the per-register rename entry layout.
package cpu_params_pkg;

    localparam int REGISTER_NUMBER_LOG     = 5;
    localparam int REORDER_BUFFER_SIZE_LOG = 3;
    localparam int REGISTER_NUMBER         = 1 << REGISTER_NUMBER_LOG;

    typedef struct packed {
        logic                               busy;
        logic [REORDER_BUFFER_SIZE_LOG-1:0] tag;
    } rrt_entry_t;

endpackage

// File: rtl/rrt_entry.sv
// One rename-table entry: busy bit plus the ROB tag of the newest producer.
// A commit only clears the entry when it comes from that same producer.
module rrt_entry #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set,
    input  logic [TAG_W-1:0] i_set_tag,
    input  logic             i_clr_req,
    input  logic [TAG_W-1:0] i_clr_tag,
    input  logic             i_flush,
    output logic             o_busy,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_clr_hit
);

    logic             r_busy;
    logic [TAG_W-1:0] r_tag;
    logic             w_clr_hit;

    // A stale commit (older tag after a WAW rename) must leave the entry alone.
    assign w_clr_hit = i_clr_req && r_busy && (r_tag == i_clr_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_tag  <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_tag  <= '0;
        end else if (i_set) begin
            r_busy <= 1'b1;
            r_tag  <= i_set_tag;
        end else if (w_clr_hit) begin
            r_busy <= 1'b0;
            r_tag  <= '0;
        end
    end

    assign o_busy    = r_busy;
    assign o_tag     = r_tag;
    assign o_clr_hit = w_clr_hit;

endmodule

// File: rtl/register_rename_table.sv
// Register status table for Tomasulo issue: per-register busy/tag, N read
// ports with a commit bypass, one dispatch write, conditional commit clear.
module register_rename_table
    import cpu_params_pkg::*;
#(
    parameter int REG_COUNT          = REGISTER_NUMBER,
    parameter int REG_IDX_W          = REGISTER_NUMBER_LOG,
    parameter int TAG_W              = REORDER_BUFFER_SIZE_LOG,
    parameter int READ_PORTS         = 2,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [READ_PORTS*REG_IDX_W-1:0] rd_idx,
    output logic [READ_PORTS-1:0]           rd_busy,
    output logic [READ_PORTS*TAG_W-1:0]     rd_tag,
    input  logic                            disp_valid,
    input  logic [REG_IDX_W-1:0]            disp_idx,
    input  logic [TAG_W-1:0]                disp_tag,
    input  logic                            cmt_valid,
    input  logic [REG_IDX_W-1:0]            cmt_idx,
    input  logic [TAG_W-1:0]                cmt_tag,
    input  logic                            flush,
    output logic [REG_IDX_W:0]              busy_count
);

    logic [REG_COUNT-1:0]        w_set;
    logic [REG_COUNT-1:0]        w_clr_req;
    logic [REG_COUNT-1:0]        w_busy;
    logic [REG_COUNT-1:0]        w_clr_hit;
    logic [TAG_W-1:0]            w_tag [REG_COUNT];
    logic [READ_PORTS-1:0]       w_rd_busy;
    logic [READ_PORTS*TAG_W-1:0] w_rd_tag;
    logic                        w_inc;
    logic                        w_dec;
    logic [REG_IDX_W:0]          r_busy_count;

    // Indices at or above REG_COUNT match no entry, so they are dropped naturally.
    for (genvar r = 0; r < REG_COUNT; r++) begin : g_entry
        if (ZERO_REG_HARDWIRED != 0 && r == 0) begin : g_zero
            assign w_set[r]     = 1'b0;
            assign w_clr_req[r] = 1'b0;
        end else begin : g_live
            assign w_set[r]     = disp_valid && (disp_idx == REG_IDX_W'(r));
            assign w_clr_req[r] = cmt_valid && (cmt_idx == REG_IDX_W'(r));
        end

        rrt_entry #(
            .TAG_W (TAG_W)
        ) u_entry (
            .clk       (clk),
            .rst_n     (reset),
            .i_set     (w_set[r]),
            .i_set_tag (disp_tag),
            .i_clr_req (w_clr_req[r]),
            .i_clr_tag (cmt_tag),
            .i_flush   (flush),
            .o_busy    (w_busy[r]),
            .o_tag     (w_tag[r]),
            .o_clr_hit (w_clr_hit[r])
        );
    end

    // Commit is bypassed to readers; dispatch is not, so r1=r1+1 sees the old producer.
    always_comb begin
        w_rd_busy = '0;
        w_rd_tag  = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (rd_idx[p*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r) && w_busy[r] && !w_clr_hit[r]) begin
                    w_rd_busy[p]                = 1'b1;
                    w_rd_tag[p*TAG_W +: TAG_W] = w_tag[r];
                end
            end
        end
    end

    assign rd_busy = w_rd_busy;
    assign rd_tag  = w_rd_tag;

    // At most one set and one clear per cycle; a set on the cleared entry cancels both.
    assign w_inc = |(w_set & ~w_busy);
    assign w_dec = |(w_clr_hit & ~w_set);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy_count <= '0;
        end else if (flush) begin
            r_busy_count <= '0;
        end else begin
            r_busy_count <= r_busy_count + {{REG_IDX_W{1'b0}}, w_inc} - {{REG_IDX_W{1'b0}}, w_dec};
        end
    end

    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_register_rename_table.sv
// Directed bench for register_rename_table: the driver pushes hand-computed
// expected reads into a queue and a monitor compares when a sample is strobed.
module tb_register_rename_table;

    localparam int REG_COUNT  = 32;
    localparam int REG_IDX_W  = 5;
    localparam int TAG_W      = 3;
    localparam int READ_PORTS = 2;
    localparam int EXP_W      = READ_PORTS + READ_PORTS*TAG_W + REG_IDX_W + 1;

    logic                            clk = 1'b0;
    logic                            reset;
    logic [READ_PORTS*REG_IDX_W-1:0] rd_idx;
    logic [READ_PORTS-1:0]           rd_busy;
    logic [READ_PORTS*TAG_W-1:0]     rd_tag;
    logic                            disp_valid;
    logic [REG_IDX_W-1:0]            disp_idx;
    logic [TAG_W-1:0]                disp_tag;
    logic                            cmt_valid;
    logic [REG_IDX_W-1:0]            cmt_idx;
    logic [TAG_W-1:0]                cmt_tag;
    logic                            flush;
    logic [REG_IDX_W:0]              busy_count;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_cmp  = 0;
    int               n_fail = 0;
    logic             chk_strobe = 1'b0;
    logic [EXP_W-1:0] mon_act;
    logic [EXP_W-1:0] mon_exp;
    string            mon_nm;

    register_rename_table #(
        .REG_COUNT          (REG_COUNT),
        .REG_IDX_W          (REG_IDX_W),
        .TAG_W              (TAG_W),
        .READ_PORTS         (READ_PORTS),
        .ZERO_REG_HARDWIRED (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (rd_idx),
        .rd_busy    (rd_busy),
        .rd_tag     (rd_tag),
        .disp_valid (disp_valid),
        .disp_idx   (disp_idx),
        .disp_tag   (disp_tag),
        .cmt_valid  (cmt_valid),
        .cmt_idx    (cmt_idx),
        .cmt_tag    (cmt_tag),
        .flush      (flush),
        .busy_count (busy_count)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drv(input logic dv, input int di, input int dt,
                       input logic cv, input int ci, input int ct, input logic fl);
        @(posedge clk);
        #1;
        disp_valid = dv;
        disp_idx   = REG_IDX_W'(di);
        disp_tag   = TAG_W'(dt);
        cmt_valid  = cv;
        cmt_idx    = REG_IDX_W'(ci);
        cmt_tag    = TAG_W'(ct);
        flush      = fl;
    endtask

    task automatic idle();
        drv(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic rd(input int p0, input int p1);
        rd_idx = {REG_IDX_W'(p1), REG_IDX_W'(p0)};
    endtask

    task automatic chk(input string nm, input logic b0, input int t0,
                       input logic b1, input int t1, input int cnt);
        logic [EXP_W-1:0] e;
        e = {b1, b0, TAG_W'(t1), TAG_W'(t0), (REG_IDX_W+1)'(cnt)};
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_strobe = 1'b1;
        #1;
        chk_strobe = 1'b0;
    endtask

    // Scoreboard monitor
    always @(posedge chk_strobe) begin
        mon_act = {rd_busy, rd_tag, busy_count};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_sample: got %h with no expected entry", mon_act);
        end else begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got busy=%b tag=%o cnt=%0d, want busy=%b tag=%o cnt=%0d",
                         mon_nm, mon_act[EXP_W-1 -: 2], mon_act[EXP_W-3 -: 6], mon_act[5:0],
                         mon_exp[EXP_W-1 -: 2], mon_exp[EXP_W-3 -: 6], mon_exp[5:0]);
            end
        end
    end

    initial begin
        reset      = 1'b0;
        disp_valid = 1'b0;
        disp_idx   = '0;
        disp_tag   = '0;
        cmt_valid  = 1'b0;
        cmt_idx    = '0;
        cmt_tag    = '0;
        flush      = 1'b0;
        rd(5, 0);
        #3;
        chk("reset_hold", 1'b0, 0, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < REG_COUNT; i++) begin
            @(negedge clk);
            rd(i, REG_COUNT-1-i);
            #1;
            chk("reset_read", 1'b0, 0, 1'b0, 0, 0);
        end

        // Dispatch then commit with bypass
        drv(1'b1, 5, 3, 1'b0, 0, 0, 1'b0);
        rd(5, 5);
        @(negedge clk); chk("disp_not_bypassed", 1'b0, 0, 1'b0, 0, 0);
        idle();
        @(negedge clk); chk("disp_visible", 1'b1, 3, 1'b1, 3, 1);
        drv(1'b0, 0, 0, 1'b1, 5, 3, 1'b0);
        @(negedge clk); chk("cmt_bypass", 1'b0, 0, 1'b0, 0, 1);
        idle();
        @(negedge clk); chk("cmt_done", 1'b0, 0, 1'b0, 0, 0);

        // WAW rename and stale commit
        drv(1'b1, 7, 1, 1'b0, 0, 0, 1'b0);
        drv(1'b1, 7, 4, 1'b0, 0, 0, 1'b0);
        idle();
        rd(7, 0);
        @(negedge clk); chk("waw_rename", 1'b1, 4, 1'b0, 0, 1);
        drv(1'b0, 0, 0, 1'b1, 7, 1, 1'b0);
        @(negedge clk); chk("stale_cmt_bypass", 1'b1, 4, 1'b0, 0, 1);
        idle();
        @(negedge clk); chk("stale_cmt_after", 1'b1, 4, 1'b0, 0, 1);

        // Same-cycle dispatch and commit
        drv(1'b1, 2, 6, 1'b0, 0, 0, 1'b0);
        idle();
        rd(2, 7);
        @(negedge clk); chk("r2_busy", 1'b1, 6, 1'b1, 4, 2);
        drv(1'b1, 2, 0, 1'b1, 2, 6, 1'b0);
        @(negedge clk); chk("collision_bypass", 1'b0, 0, 1'b1, 4, 2);
        idle();
        @(negedge clk); chk("collision_after", 1'b1, 0, 1'b1, 4, 2);
        drv(1'b1, 10, 5, 1'b1, 7, 4, 1'b0);
        idle();
        rd(10, 7);
        @(negedge clk); chk("disp_cmt_diff", 1'b1, 5, 1'b0, 0, 2);

        // Zero register and flush
        drv(1'b1, 0, 2, 1'b0, 0, 0, 1'b0);
        idle();
        rd(0, 2);
        @(negedge clk); chk("zero_reg", 1'b0, 0, 1'b1, 0, 2);
        drv(1'b1, 1, 1, 1'b0, 0, 0, 1'b0);
        drv(1'b1, 3, 2, 1'b0, 0, 0, 1'b0);
        drv(1'b1, 9, 7, 1'b0, 0, 0, 1'b0);
        idle();
        rd(9, 1);
        @(negedge clk); chk("pre_flush", 1'b1, 7, 1'b1, 1, 5);
        drv(1'b1, 4, 3, 1'b0, 0, 0, 1'b1);
        rd(4, 9);
        @(negedge clk); chk("flush_pending", 1'b0, 0, 1'b1, 7, 5);
        idle();
        for (int i = 0; i < REG_COUNT; i++) begin
            @(negedge clk);
            rd(i, REG_COUNT-1-i);
            #1;
            chk("flush_clear", 1'b0, 0, 1'b0, 0, 0);
        end

        // Asynchronous reset mid-operation
        drv(1'b1, 1, 1, 1'b0, 0, 0, 1'b0);
        drv(1'b1, 2, 2, 1'b0, 0, 0, 1'b0);
        drv(1'b1, 3, 3, 1'b0, 0, 0, 1'b0);
        idle();
        rd(3, 1);
        @(negedge clk); chk("pre_reset", 1'b1, 3, 1'b1, 1, 3);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset", 1'b0, 0, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); chk("post_reset", 1'b0, 0, 1'b0, 0, 0);

        // Final report
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover_expected: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/register_rename_table.md
# register_rename_table

Parametrised register status table for the Tomasulo issue stage. It maps each architectural register to the reorder-buffer tag of its newest in-flight producer and keeps an explicit busy bit per register. It provides N combinational read ports for operand lookup, one dispatch write, one commit-side conditional clear, and a full flush for mispredict recovery. It sits between decode/dispatch and the reservation stations, alongside the reorder buffer, and also maintains a count of busy registers.

## Interface
Parameters:
- REG_COUNT, 32: number of architectural registers.
- REG_IDX_W, 5: register index width, equal to clog2(REG_COUNT).
- TAG_W, 3: ROB tag width (ROB depth is 2^TAG_W).
- READ_PORTS, 2: number of operand lookup ports, 1 or more.
- ZERO_REG_HARDWIRED, 1: when 1, register 0 is never busy.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_idx  in  READ_PORTS*REG_IDX_W  lookup indices; port p occupies bits [p*REG_IDX_W +: REG_IDX_W].
- rd_busy  out  READ_PORTS  per port: the register awaits a ROB result.
- rd_tag  out  READ_PORTS*TAG_W  per port: producer tag. Meaningful only when busy; drives 0 when not busy.
- disp_valid  in  1  dispatch writes a new producer mapping.
- disp_idx  in  REG_IDX_W  destination register of the dispatch.
- disp_tag  in  TAG_W  ROB tag assigned to the dispatch.
- cmt_valid  in  1  the ROB commits an instruction with a register destination.
- cmt_idx  in  REG_IDX_W  destination register of the committing instruction.
- cmt_tag  in  TAG_W  ROB tag of the committing instruction.
- flush  in  1  mispredict recovery; clears every mapping.
- busy_count  out  REG_IDX_W+1  number of registers currently busy.

## Operation
- State per register: busy (1 bit) and tag (TAG_W bits).
- Reset (reset low, asynchronous): all busy bits clear, all tags 0, busy_count 0. All outputs are 0 while reset is held.
- Dispatch: when disp_valid is high, the entry at disp_idx becomes busy=1 with tag=disp_tag. This overwrites any older mapping (WAW rename).
- Commit: when cmt_valid is high, the entry at cmt_idx is cleared only if it is busy and its stored tag equals cmt_tag. If the tags differ, a younger producer owns the register and the entry is unchanged.
- Commit and dispatch in the same cycle to the same register: dispatch wins, so the entry ends busy with disp_tag.
- Flush: all entries clear at the next edge. Flush overrides dispatch and commit in the same cycle.
- Zero register: when ZERO_REG_HARDWIRED=1, a dispatch or commit to index 0 is ignored, and reads of index 0 always return busy=0, tag=0.
- Out-of-range indices (index ≥ REG_COUNT) are ignored on writes and read as not busy.
- Read ports are combinational from the current state, with a commit bypass:
  - If cmt_valid is high, cmt_idx matches the read index, and the stored entry is busy with tag equal to cmt_tag, the port returns busy=0.
  - Dispatch is not bypassed. A same-cycle read of disp_idx returns the old mapping, which is the correct source-operand semantics for an instruction such as r1=r1+1.
- busy_count: registered. It equals the popcount of the busy bits after each edge and is maintained incrementally:
  - +1 when a dispatch sets a previously idle entry.
  - −1 when a commit clears an entry.
  - Net 0 when a dispatch overwrites a busy entry, or when a dispatch and a matching commit hit the same entry.
  - 0 after flush.
  - When a dispatch and a commit hit different registers in the same cycle, both effects apply.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: 1 cycle. A dispatch at edge k is visible on read ports after edge k.
- A commit clear is visible in the same cycle through the bypass, and in state after the edge.
- busy_count reflects the state after each edge.
- Flush asserted at edge k: every rd_busy is 0 after edge k. Reset behaves the same way asynchronously, mid-operation included.
- No handshakes: dispatch and commit are single-cycle pulses that always complete.

## Structure
- Shared package cpu_params_pkg holds REGISTER_NUMBER_LOG, REORDER_BUFFER_SIZE_LOG and a packed struct rrt_entry_t {busy, tag}. The parameter defaults above derive from these.
- Sub-module rrt_entry, one instance per register, generated in a loop:
  - Holds busy and tag; async active-low reset.
  - Inputs: set, set_tag, clr_req, clr_tag, flush.
  - Outputs: the entry value and a clr_hit signal used by the read bypass and busy_count.
- The top level performs the index decode, READ_PORTS read muxes with bypass, and the busy_count update.

## Test plan
- Reset then read: hold reset low, then release. For all indices on both ports, rd_busy=0 and rd_tag=0; busy_count=0.
- Dispatch then commit: dispatch r5 tag 3 → next cycle rd(5) gives busy=1, tag=3 and busy_count=1. Commit r5 tag 3 → rd(5) shows busy=0 in the same cycle (bypass); busy_count=0 after the edge.
- WAW stale commit: dispatch r7 tag 1, then r7 tag 4 → busy_count=1. Commit r7 tag 1 → r7 stays busy with tag 4; busy_count stays 1.
- Same-cycle collision: r2 busy with tag 6. In one cycle, dispatch r2 tag 0 and commit r2 tag 6 → r2 ends busy with tag 0; busy_count unchanged. A same-cycle read of r2 returns busy=0 via the commit bypass, since dispatch is not bypassed.
- Zero register and flush: dispatch r0 tag 2 → r0 reads not busy. Dispatch r1, r3 and r9, then assert flush together with dispatch r4 → all entries read not busy and busy_count=0.
- Async reset mid-operation: with 3 registers busy, pull reset low between clock edges → outputs go to 0 immediately without waiting for a clock edge.
